// File: rtl/idx_loop_pkg.sv
// Shared types and helpers for the nested-loop index generator and its per-level counters.
// Pure declarations: no logic, no latency, no flow control of its own.
package idx_loop_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lc_state_t;

    // Smallest legal index width and level count
    localparam int MIN_WIDTH = 1;
    localparam int MIN_LVL   = 1;

    function automatic int lvl_off(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/idx_lvl_cnt.sv
// One loop level: WIDTH-bit index that steps on en and wraps to 0 at its limit.
// Updates on the edge after en; no backpressure of its own (en already folds in the consumer's adv).
module idx_lvl_cnt
    import idx_loop_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load0,
    input  logic             en,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] ptr,
    output logic             at_lim
);

    assign at_lim = (ptr == lim);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (load0) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= at_lim ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/idx_loop_ctr.sv
// Nested-loop index generator: first tuple visible the cycle after start, one tuple per accepted cycle.
// adv low stalls and holds the current tuple; done pulses one cycle after the final tuple is accepted.
module idx_loop_ctr
    import idx_loop_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int NUM_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     clr,
    input  logic [NUM_LVL*WIDTH-1:0] lim_i,
    input  logic                     adv,
    output logic [NUM_LVL*WIDTH-1:0] ptr_o,
    output logic                     valid_o,
    output logic                     last_o,
    output logic [NUM_LVL-1:0]       wrap_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int PW = NUM_LVL * WIDTH;

    if (WIDTH < MIN_WIDTH || NUM_LVL < MIN_LVL) begin : g_cfg_err
        $error("idx_loop_ctr: WIDTH and NUM_LVL must both be at least 1");
    end

    lc_state_t          state;
    logic [PW-1:0]      lim_q;
    logic [NUM_LVL-1:0] at_lim;
    logic [NUM_LVL-1:0] en;
    logic               run;
    logic               accept;
    logic               fin;
    logic               load0;

    assign run     = (state == RUN);
    assign accept  = run & adv;
    assign last_o  = run & (&at_lim);
    assign fin     = accept & last_o;
    assign load0   = (state == IDLE) & start & ~clr;
    assign valid_o = run;
    assign busy_o  = run;
    assign en[0]   = accept;

    // The final accept needs no special reload: every level sits at its limit, so the carry wraps all to 0
    for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
        idx_lvl_cnt #(
            .WIDTH (WIDTH)
        ) u_cnt (
            .clk    (clk),
            .rstn   (rstn),
            .clr    (clr),
            .load0  (load0),
            .en     (en[k]),
            .lim    (lim_q[lvl_off(k, WIDTH) +: WIDTH]),
            .ptr    (ptr_o[lvl_off(k, WIDTH) +: WIDTH]),
            .at_lim (at_lim[k])
        );

        assign wrap_o[k] = en[k] & at_lim[k];

        if (k < NUM_LVL - 1) begin : g_carry
            assign en[k+1] = wrap_o[k];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            lim_q  <= '0;
            done_o <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        lim_q <= lim_i;
                    end
                end
                RUN: begin
                    if (fin) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idx_loop_ctr.sv
// Bench for idx_loop_ctr: directed vector table, hand-written corner sequences and random traffic
// checked against a linear-count model of the nested loops.
module tb_idx_loop_ctr;

    localparam int W = 6;
    localparam int N = 2;
    localparam int P = W * N;

    localparam logic [P-1:0] LIM21  = {6'd1, 6'd2};
    localparam logic [P-1:0] LIM00  = {6'd0, 6'd0};
    localparam logic [P-1:0] LIM630 = {6'd0, 6'd63};
    localparam logic [P-1:0] LIMALT = {6'd3, 6'd5};

    logic         clk   = 1'b0;
    logic         rstn  = 1'b1;
    logic         start = 1'b0;
    logic         clr   = 1'b0;
    logic         adv   = 1'b0;
    logic [P-1:0] lim_i = '0;
    logic [P-1:0] ptr_o;
    logic         valid_o;
    logic         last_o;
    logic [N-1:0] wrap_o;
    logic         busy_o;
    logic         done_o;

    always #5 clk = ~clk;

    idx_loop_ctr #(
        .WIDTH   (W),
        .NUM_LVL (N)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .clr     (clr),
        .lim_i   (lim_i),
        .adv     (adv),
        .ptr_o   (ptr_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .wrap_o  (wrap_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    int tests = 0;
    int fails = 0;

    // Model: the run is a count m_n over 0 .. product(lim+1)-1; tuples are its mixed-radix digits
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_n    = 0;
    int m_lim [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_span(input int k);
        int p = 1;
        for (int j = 0; j <= k; j++) p = p * (m_lim[j] + 1);
        return p;
    endfunction

    function automatic logic [P-1:0] m_ptr();
        logic [P-1:0] r = '0;
        int rem = m_n;
        for (int k = 0; k < N; k++) begin
            r[k*W +: W] = W'(rem % (m_lim[k] + 1));
            rem = rem / (m_lim[k] + 1);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] m_wrap();
        logic [N-1:0] r = '0;
        for (int k = 0; k < N; k++)
            r[k] = m_run && adv && ((m_n % m_span(k)) == m_span(k) - 1);
        return r;
    endfunction

    function automatic logic m_last();
        return m_run && (m_n == m_span(N-1) - 1);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_n    = 0;
        for (int k = 0; k < N; k++) m_lim[k] = 0;
    endtask

    // Called just after a rising edge, with the inputs that were sampled on it
    task automatic model_edge();
        if (!rstn) begin
            model_reset();
        end else if (clr) begin
            m_run  = 1'b0;
            m_n    = 0;
            m_done = 1'b0;
        end else if (!m_run) begin
            m_done = 1'b0;
            if (start) begin
                m_run = 1'b1;
                m_n   = 0;
                for (int k = 0; k < N; k++) m_lim[k] = int'(lim_i[k*W +: W]);
            end
        end else begin
            m_done = 1'b0;
            if (adv) begin
                if (m_n == m_span(N-1) - 1) begin
                    m_run  = 1'b0;
                    m_n    = 0;
                    m_done = 1'b1;
                end else begin
                    m_n = m_n + 1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " ptr"},   64'(ptr_o),   64'(m_ptr()));
        chk({tag, " valid"}, 64'(valid_o), 64'(m_run));
        chk({tag, " last"},  64'(last_o),  64'(m_last()));
        chk({tag, " wrap"},  64'(wrap_o),  64'(m_wrap()));
        chk({tag, " busy"},  64'(busy_o),  64'(m_run));
        chk({tag, " done"},  64'(done_o),  64'(m_done));
    endtask

    task automatic apply(input logic s, input logic c, input logic a, input logic [P-1:0] l);
        @(negedge clk);
        start = s;
        clr   = c;
        adv   = a;
        lim_i = l;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic cyc(input logic s, input logic c, input logic a, input logic [P-1:0] l, input string tag);
        apply(s, c, a, l);
        check_model(tag);
        tick();
    endtask

    // mode 0: adv held high; mode 1: adv pattern 1,0,0,1; mode 2: adv high with start and new limits held
    task automatic run_seq(input string tag, input int mode, input logic [P-1:0] l,
                           output int acc, output bit got_done, output logic [N-1:0] wlast);
        logic a;
        acc      = 0;
        got_done = 1'b0;
        wlast    = '0;
        for (int i = 0; i < 300 && !got_done; i++) begin
            a = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            apply(mode == 2, 1'b0, a, (mode == 2) ? LIMALT : l);
            check_model(tag);
            if (done_o) begin
                got_done = 1'b1;
                start    = 1'b0;
            end else if (a && valid_o) begin
                acc++;
                if (last_o) wlast = wrap_o;
            end
            tick();
        end
        if (!got_done) chk({tag, " timeout"}, 64'(got_done), 64'd1);
    endtask

    typedef struct {
        logic         s;
        logic         c;
        logic         a;
        logic [P-1:0] l;
        logic [P-1:0] ptr;
        logic         valid;
        logic         last;
        logic [N-1:0] wrap;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int           acc;
        bit           got_done;
        logic [N-1:0] wl;
        logic [P-1:0] rl;

        model_reset();
        vecs[0] = '{1'b1, 1'b0, 1'b0, LIM21, 12'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, LIM21, 12'h000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, LIM21, 12'h001, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, LIM21, 12'h002, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, LIM21, 12'h040, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, LIM21, 12'h041, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, LIM21, 12'h042, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, LIM21, 12'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, LIM21, 12'h000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        #1 rstn = 1'b0;
        #1;
        chk("reset ptr",   64'(ptr_o),   64'd0);
        chk("reset valid", 64'(valid_o), 64'd0);
        chk("reset last",  64'(last_o),  64'd0);
        chk("reset wrap",  64'(wrap_o),  64'd0);
        chk("reset busy",  64'(busy_o),  64'd0);
        chk("reset done",  64'(done_o),  64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Limits (2,1), adv held high
        foreach (vecs[i]) begin
            apply(vecs[i].s, vecs[i].c, vecs[i].a, vecs[i].l);
            chk($sformatf("tbl%0d ptr", i),   64'(ptr_o),   64'(vecs[i].ptr));
            chk($sformatf("tbl%0d valid", i), 64'(valid_o), 64'(vecs[i].valid));
            chk($sformatf("tbl%0d last", i),  64'(last_o),  64'(vecs[i].last));
            chk($sformatf("tbl%0d wrap", i),  64'(wrap_o),  64'(vecs[i].wrap));
            chk($sformatf("tbl%0d busy", i),  64'(busy_o),  64'(vecs[i].busy));
            chk($sformatf("tbl%0d done", i),  64'(done_o),  64'(vecs[i].done));
            tick();
        end

        // Stalls: adv 1,0,0,1 still yields exactly six accepts
        cyc(1'b1, 1'b0, 1'b0, LIM21, "stall start");
        run_seq("stall", 1, LIM21, acc, got_done, wl);
        chk("stall accepts", 64'(acc), 64'd6);
        chk("stall done", 64'(got_done), 64'd1);

        // Single-tuple sequence
        cyc(1'b1, 1'b0, 1'b0, LIM00, "one start");
        apply(1'b0, 1'b0, 1'b1, LIM00);
        check_model("one tuple");
        chk("one last", 64'(last_o), 64'd1);
        chk("one wrap", 64'(wrap_o), 64'd3);
        tick();
        apply(1'b0, 1'b0, 1'b0, LIM00);
        chk("one done", 64'(done_o), 64'd1);
        tick();
        apply(1'b0, 1'b0, 1'b0, LIM00);
        chk("one done drop", 64'(done_o), 64'd0);
        tick();

        // Full-range inner level
        cyc(1'b1, 1'b0, 1'b0, LIM630, "l63 start");
        run_seq("l63", 0, LIM630, acc, got_done, wl);
        chk("l63 accepts", 64'(acc), 64'd64);
        chk("l63 final wrap", 64'(wl), 64'd3);

        // clr at tuple (1,1)
        cyc(1'b1, 1'b0, 1'b0, LIM21, "clr start");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, LIM21, "clr run");
        apply(1'b0, 1'b1, 1'b1, LIM21);
        chk("clr at tuple", 64'(ptr_o), 64'h041);
        tick();
        apply(1'b0, 1'b0, 1'b0, LIM21);
        chk("clr valid", 64'(valid_o), 64'd0);
        chk("clr ptr",   64'(ptr_o),   64'd0);
        chk("clr done",  64'(done_o),  64'd0);
        tick();

        // start together with clr stays idle
        cyc(1'b1, 1'b1, 1'b0, LIM21, "startclr");
        apply(1'b0, 1'b0, 1'b0, LIM21);
        chk("startclr valid", 64'(valid_o), 64'd0);
        chk("startclr busy",  64'(busy_o),  64'd0);
        tick();

        // Asynchronous reset mid-run
        cyc(1'b1, 1'b0, 1'b0, LIM21, "arst start");
        cyc(1'b0, 1'b0, 1'b1, LIM21, "arst run");
        cyc(1'b0, 1'b0, 1'b1, LIM21, "arst run");
        apply(1'b0, 1'b0, 1'b0, LIM21);
        chk("arst pre ptr", 64'(ptr_o), 64'h002);
        rstn = 1'b0;
        #1;
        chk("arst ptr",   64'(ptr_o),   64'd0);
        chk("arst valid", 64'(valid_o), 64'd0);
        chk("arst last",  64'(last_o),  64'd0);
        chk("arst busy",  64'(busy_o),  64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        // start with new limits in RUN is ignored
        cyc(1'b1, 1'b0, 1'b0, LIM21, "restart start");
        run_seq("restart", 2, LIM21, acc, got_done, wl);
        chk("restart accepts", 64'(acc), 64'd6);
        chk("restart done", 64'(got_done), 64'd1);
        cyc(1'b0, 1'b0, 1'b0, LIM21, "restart idle");

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++)
                rl[k*W +: W] = ($urandom_range(0, 15) == 0) ? W'(63) : W'($urandom_range(0, 3));
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                1'($urandom_range(0, 1)), rl, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idx_loop_ctr.md
# idx_loop_ctr

Parametrised nested-loop index generator: the multi-level successor to the single x-index pointer register. It sequences up to `NUM_LVL` indices, each `WIDTH` bits wide, through every combination from 0 to a per-level limit, innermost level fastest. It uses a start/busy/done handshake and accepts consumer backpressure. It sits between the control FSM and the datapath address generators of the convolution core.

## Interface
- `WIDTH`, 6: bits per index level.
- `NUM_LVL`, 2: number of nested levels, ≥1. Level 0 is innermost.
- `clk` in 1: clock; all state changes on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a sequence; honoured only in IDLE.
- `clr` in 1: synchronous abort/clear; highest priority after reset.
- `lim_i` in `NUM_LVL*WIDTH`: last index per level, level k at bits `[k*WIDTH +: WIDTH]`; sampled only on an accepted start.
- `adv` in 1: consumer accepts the current index tuple.
- `ptr_o` out `NUM_LVL*WIDTH`: current index tuple, same packing as `lim_i`.
- `valid_o` out 1: `ptr_o` is a live tuple.
- `last_o` out 1: `valid_o` is high and every level equals its limit.
- `wrap_o` out `NUM_LVL`: bit k is high when an accepted advance wraps level k.
- `busy_o` out 1: FSM is in RUN.
- `done_o` out 1: one-cycle pulse after the final tuple is accepted.

## Operation
- FSM states are IDLE and RUN. Reset state is IDLE.
- Reset values: `ptr_o`=0, `valid_o`=0, `last_o`=0, `wrap_o`=0, `busy_o`=0, `done_o`=0, limit registers=0.
- IDLE → RUN on `start` with `clr` low. All pointers load 0 and `lim_i` is latched. `valid_o`=`busy_o`=1.
- In RUN, `valid_o` is 1 in every cycle.
  - An accept occurs in a cycle with `adv`=1.
  - On an accept, level 0 increments by 1.
  - If level k equals its limit and all lower levels wrap, level k reloads 0 and carries into level k+1. Otherwise level k+1 holds.
- Final accept: an accept while `last_o`=1.
  - All pointers return to 0 and the FSM goes to IDLE.
  - `done_o` pulses for one cycle.
  - All `wrap_o` bits assert on the final-accept cycle.
- `wrap_o[k]` = `adv` & RUN & (levels 0..k all at limit). It is combinational from registered state and `adv`.
- `last_o` is combinational from registered state.
- A limit of 0 makes that level degenerate: it wraps on every carry-in.
  - Sequence length is the product of (lim_k+1). The maximum is 2^(WIDTH·NUM_LVL) tuples.
  - All-zero limits give a single-tuple sequence.
- `start` in RUN is ignored and the limits are not resampled.
- `start` in the final-accept cycle is ignored, so a new run needs `start` in a later cycle.
- `clr` in any state: FSM goes to IDLE, pointers go to 0, and `done_o` is not asserted. `clr` wins over a simultaneous `start` or `adv`.
- Pointer arithmetic is unsigned `WIDTH`-bit.
  - The compare is equality against the limit, so no overflow is reachable.
  - A limit of 2^WIDTH−1 is legal.
- Reset mid-run forces the reset values immediately, independent of `clk`.

## Timing
- `start` sampled at edge t: `valid_o`=1 with `ptr_o`=0 from just after edge t.
- Accept at edge t: the next tuple is visible just after edge t. Throughput is one tuple per cycle with `adv` held high.
- `adv`=0 stalls. `ptr_o`, `valid_o` and `last_o` hold indefinitely.
- Final accept at edge t: `done_o`=1 and `busy_o`=0 for the cycle following edge t. `done_o` drops after edge t+1.
- There is no combinational path from `start` or `clr` to any output.

## Structure
- Package `idx_loop_pkg`:
  - the state enum (IDLE, RUN);
  - a `WIDTH`/`NUM_LVL` sanity localparam;
  - a helper returning the slice offset `k*WIDTH`.
- Sub-module `idx_lvl_cnt`, instantiated `NUM_LVL` times in a generate loop.
  - Inputs: `clk`, `rstn`, `clr`, `load0`, `en`, `lim`.
  - Outputs: `ptr`, `at_lim`.
  - It holds a `WIDTH`-bit register with clear > load0 > en priority. The enable wraps to 0 at the limit.
- The top level holds the FSM, the carry chain (`en[k+1] = en[k] & at_lim[k]`), the limit registers and `done_o`.

## Test plan
- WIDTH=6, NUM_LVL=2, limits (2,1), `adv` held high.
  - Required `ptr_o` sequence (lvl0,lvl1): (0,0) (1,0) (2,0) (0,1) (1,1) (2,1).
  - `last_o` high only on (2,1); `wrap_o`=01 on the 3rd accept and 11 on the 6th.
  - `done_o` pulses one cycle later, then IDLE with `ptr_o`=0.
- Same limits with `adv` toggled 1,0,0,1:
  - the tuple holds through the stall cycles;
  - there are no skipped or duplicated tuples;
  - the total is still 6 accepts.
- Limits (0,0): `start` → a single tuple (0,0) with `last_o`=1; one accept → `done_o` pulse.
- Limits (63,0): sequence 0..63 in level 0, then `wrap_o`=11 and `done_o`.
- Abort cases:
  - `clr` at tuple (1,1) → next cycle IDLE, `ptr_o`=0, and no `done_o`;
  - `start` with `clr` in the same cycle → stays IDLE;
  - `rstn` low mid-run → all outputs reach reset values with no clock edge.
- `start` pulsed again in RUN with different `lim_i` → ignored; the original sequence and its length complete unchanged.
